// File: rtl/trans_fifo_rd_ctrl_if.sv
// FIFO read-port and XGMII TX bundle between the read-side controller and its neighbours.
// master = controller side, slave = FIFO/MAC side.
interface trans_fifo_rd_ctrl_if;
  logic [71:0] fifo_q;
  logic [9:0]  fifo_rdusedw;
  logic        fifo_rdempty;
  logic        fifo_rdreq;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;

  modport master (
    input  fifo_q, fifo_rdusedw, fifo_rdempty,
    output fifo_rdreq, xgmii_txd, xgmii_txc
  );

  modport slave (
    output fifo_q, fifo_rdusedw, fifo_rdempty,
    input  fifo_rdreq, xgmii_txd, xgmii_txc
  );
endinterface

// File: rtl/trans_fifo_rd_ctrl.sv
// Read-side controller for the 72-bit transceiver TX FIFO: gates frame start on fill level or timeout,
// streams words onto XGMII, enforces the inter-packet gap and turns underrun into an error frame.
module trans_fifo_rd_ctrl #(
  parameter int unsigned START_THRESH = 16,
  parameter int unsigned START_TMO    = 64,
  parameter int unsigned IPG_WORDS    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 link_up,
  trans_fifo_rd_ctrl_if.master bus,
  output logic                 underrun,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          err_cnt
);

  localparam int unsigned TMO_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam int unsigned IPG_W = (IPG_WORDS > 1) ? $clog2(IPG_WORDS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'(IPG_WORDS - 1);
  localparam logic [63:0] IDLE_TXD = 64'h0707070707070707;
  localparam logic [63:0] ERR_TXD  = 64'hFEFEFEFEFEFEFEFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_FLUSH,
    S_IPG
  } state_e;

  state_e           state_q, state_d;
  logic             q_vld_q, q_vld_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [IPG_W-1:0] ipg_q, ipg_d;
  logic [63:0]      txd_q, txd_d;
  logic [7:0]       txc_q, txc_d;
  logic             underrun_q, underrun_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;

  logic             rdreq, sop, eop, err_inc, frame_inc, start_ok;
  logic [7:0]       q_ctrl;
  logic [63:0]      q_data;

  assign q_ctrl = bus.fifo_q[71:64];
  assign q_data = bus.fifo_q[63:0];
  assign sop    = q_ctrl[0] && (q_data[7:0] == 8'hFB);

  always_comb begin
    eop = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (q_ctrl[i] && (q_data[8*i +: 8] == 8'hFD)) eop = 1'b1;
    end
  end

  assign start_ok = link_up &&
                    ((32'(bus.fifo_rdusedw) >= START_THRESH) ||
                     (!bus.fifo_rdempty && (tmo_q == TMO_LAST)));

  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    ipg_d      = '0;
    txd_d      = IDLE_TXD;
    txc_d      = '1;
    underrun_d = 1'b0;
    rdreq      = 1'b0;
    err_inc    = 1'b0;
    frame_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.fifo_rdempty) tmo_d = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
        if (start_ok) state_d = S_START;
      end
      // First cycle issues the SOP read; second cycle judges it and, if it is a SOP,
      // already requests the next word so the stream stays back-to-back.
      S_START: begin
        if (!q_vld_q) begin
          rdreq = ~bus.fifo_rdempty;
        end else if (sop) begin
          txd_d = q_data;
          txc_d = q_ctrl;
          rdreq = ~bus.fifo_rdempty & ~eop;
          if (eop) begin
            frame_inc = 1'b1;
            state_d   = S_IPG;
          end else begin
            state_d   = S_STREAM;
          end
        end else begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STREAM: begin
        rdreq = ~bus.fifo_rdempty & ~(q_vld_q & eop);
        if (q_vld_q && eop) begin
          txd_d     = q_data;
          txc_d     = q_ctrl;
          frame_inc = 1'b1;
          state_d   = S_IPG;
        end else if (!q_vld_q || !link_up) begin
          txd_d      = ERR_TXD;
          underrun_d = 1'b1;
          err_inc    = 1'b1;
          state_d    = S_FLUSH;
        end else begin
          txd_d = q_data;
          txc_d = q_ctrl;
        end
      end
      S_FLUSH: begin
        rdreq = ~bus.fifo_rdempty & ~(q_vld_q & eop);
        if (q_vld_q && eop) state_d = S_IPG;
      end
      S_IPG: begin
        if (ipg_q == IPG_LAST) state_d = S_IDLE;
        else                   ipg_d   = ipg_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    q_vld_d     = rdreq;
    frame_cnt_d = frame_cnt_q + {15'd0, frame_inc};
    err_cnt_d   = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      q_vld_q     <= 1'b0;
      tmo_q       <= '0;
      ipg_q       <= '0;
      txd_q       <= IDLE_TXD;
      txc_q       <= '1;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      q_vld_q     <= q_vld_d;
      tmo_q       <= tmo_d;
      ipg_q       <= ipg_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.fifo_rdreq = rdreq;
  assign bus.xgmii_txd  = txd_q;
  assign bus.xgmii_txc  = txc_q;
  assign underrun       = underrun_q;
  assign frame_cnt      = frame_cnt_q;
  assign err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_trans_fifo_rd_ctrl.sv
// Scoreboard bench for trans_fifo_rd_ctrl: a queue-based FIFO model feeds the DUT, expected XGMII
// words are queued as frames are loaded, and a monitor pops and compares every non-idle output word.
module tb_trans_fifo_rd_ctrl;
  localparam int unsigned START_THRESH = 16;
  localparam int unsigned START_TMO    = 64;
  localparam int unsigned IPG_WORDS    = 2;
  localparam logic [63:0] IDLE_D = 64'h0707070707070707;
  localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  c;
    logic        und;
    logic        sop;
    logic        eop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic        underrun;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  trans_fifo_rd_ctrl_if bus();

  trans_fifo_rd_ctrl #(
    .START_THRESH(START_THRESH),
    .START_TMO   (START_TMO),
    .IPG_WORDS   (IPG_WORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .link_up  (link_up),
    .bus      (bus),
    .underrun (underrun),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [71:0] mem[$];
  logic [71:0] frm[$];
  int unsigned sop_rd[$];
  int unsigned cyc = 0;
  int unsigned reads = 0;
  int          checks = 0;
  int          errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  // Frame: SOP word, random data words, terminate word with idles above the FD lane.
  function automatic void make_frame(input int unsigned n, input int eop_lane);
    logic [63:0] d;
    logic [7:0]  c;
    int unsigned lane;
    frm.delete();
    for (int unsigned i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      c = '0;
      if (i == 0) begin
        d[7:0] = 8'hFB;
        c      = 8'h01;
      end else if (i == n - 1) begin
        lane = (eop_lane < 0) ? $urandom_range(0, 7) : int'(eop_lane);
        c    = 8'hFF << lane;
        d[8*lane +: 8] = 8'hFD;
        for (int unsigned j = lane + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
      end
      frm.push_back({c, d});
    end
  endfunction

  task automatic expect_words(input int unsigned k, input bit with_err);
    exp_t e;
    for (int unsigned i = 0; i < k; i++) begin
      e.d   = frm[i][63:0];
      e.c   = frm[i][71:64];
      e.und = 1'b0;
      e.sop = (i == 0);
      e.eop = (i == frm.size() - 1);
      exp_q.push_back(e);
    end
    if (with_err) begin
      e.d = ERR_D; e.c = 8'hFF; e.und = 1'b1; e.sop = 1'b0; e.eop = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic load_fifo(input int unsigned from, input int unsigned to);
    for (int unsigned i = from; i < to; i++) mem.push_back(frm[i]);
  endtask

  task automatic wait_drain(input string nm);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || mem.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending required 0", nm, exp_q.size());
    end
    repeat (IPG_WORDS + 8) @(negedge clk);
  endtask

  // FIFO model: rdreq sampled mid-cycle, data/status updated just after the edge.
  initial begin : fifo_model
    logic        rd;
    int unsigned rc;
    logic [71:0] w;
    bus.fifo_q       = '0;
    bus.fifo_rdempty = 1'b1;
    bus.fifo_rdusedw = '0;
    forever begin
      @(negedge clk);
      rd = bus.fifo_rdreq;
      rc = cyc;
      if (rd === 1'b1) begin
        checks++;
        if (bus.fifo_rdempty) begin
          errors++;
          $display("FAIL rdreq_when_empty: got rdreq=1 required 0 at cycle %0d", rc);
        end
      end
      @(posedge clk);
      #1;
      if (rd === 1'b1 && mem.size() != 0) begin
        w = mem.pop_front();
        bus.fifo_q = w;
        reads++;
        if (w[64] && w[7:0] == 8'hFB) sop_rd.push_back(rc);
      end
      bus.fifo_rdempty = (mem.size() == 0);
      bus.fifo_rdusedw = 10'(mem.size());
    end
  end

  initial begin : monitor
    exp_t        e;
    int unsigned gap, r;
    bit          after_eop;
    gap = 0;
    after_eop = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        after_eop = 0;
        continue;
      end
      if (bus.xgmii_txd === IDLE_D && bus.xgmii_txc === 8'hFF) begin
        gap++;
        checks++;
        if (underrun !== 1'b0) begin
          errors++;
          $display("FAIL underrun_on_idle: got %b required 0 at cycle %0d", underrun, cyc);
        end
      end else begin
        if (after_eop) begin
          checks++;
          if (gap < IPG_WORDS) begin
            errors++;
            $display("FAIL ipg_gap: got %0d idle words required >= %0d", gap, IPG_WORDS);
          end
        end
        after_eop = 0;
        gap = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got txd=%h txc=%h required idle", bus.xgmii_txd, bus.xgmii_txc);
        end else begin
          e = exp_q.pop_front();
          if (bus.xgmii_txd !== e.d || bus.xgmii_txc !== e.c || underrun !== e.und) begin
            errors++;
            $display("FAIL word: got txd=%h txc=%h und=%b required txd=%h txc=%h und=%b",
                     bus.xgmii_txd, bus.xgmii_txc, underrun, e.d, e.c, e.und);
          end
          if (e.sop) begin
            checks++;
            if (sop_rd.size() == 0) begin
              errors++;
              $display("FAIL sop_latency: got SOP with no SOP read required a prior read");
            end else begin
              r = sop_rd.pop_front();
              if (cyc != r + 2) begin
                errors++;
                $display("FAIL sop_latency: got %0d cycles required 2", cyc - r);
              end
            end
          end
          if (e.eop) after_eop = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish before 1ms");
    $fatal(1);
  end

  initial begin : stimulus
    int unsigned n, base;
    rst_n   = 1'b1;
    link_up = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_txd",      bus.xgmii_txd,  IDLE_D);
    chk("reset_txc",      bus.xgmii_txc,  64'hFF);
    chk("reset_rdreq",    bus.fifo_rdreq, 64'h0);
    chk("reset_underrun", underrun,       64'h0);
    chk("reset_frame",    frame_cnt,      64'h0);
    chk("reset_err",      err_cnt,        64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Empty FIFO: nothing happens.
    repeat (100) @(negedge clk);
    chk("t1_frame", frame_cnt, 64'd0);
    chk("t1_err",   err_cnt,   64'd0);

    // 20-word frame above threshold, EOP in lane 3.
    base = reads;
    make_frame(20, 3);
    expect_words(20, 1'b0);
    load_fifo(0, 20);
    wait_drain("t2");
    chk("t2_reads", reads - base, 64'd20);
    chk("t2_frame", frame_cnt, 64'd1);

    // 4-word frame below threshold: starts only on the timeout.
    make_frame(4, -1);
    expect_words(4, 1'b0);
    load_fifo(0, 4);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (bus.fifo_rdreq === 1'b1) break;
      n++;
    end
    chk("t3_tmo_cycles", n, START_TMO);
    wait_drain("t3");
    chk("t3_frame", frame_cnt, 64'd2);

    // 30-word frame starved after 10 words, then the rest plus a clean frame.
    make_frame(30, -1);
    expect_words(10, 1'b1);
    load_fifo(0, 10);
    wait_drain("t4a");
    chk("t4_err", err_cnt, 64'd1);
    load_fifo(10, 30);
    make_frame(20, -1);
    expect_words(20, 1'b0);
    load_fifo(0, 20);
    wait_drain("t4b");
    chk("t4_frame", frame_cnt, 64'd3);
    chk("t4_err2",  err_cnt,   64'd1);

    // Junk head word without SOP, then a valid frame.
    mem.push_back({8'h00, $urandom, $urandom});
    make_frame(20, -1);
    expect_words(20, 1'b0);
    load_fifo(0, 20);
    wait_drain("t5");
    chk("t5_frame", frame_cnt, 64'd4);
    chk("t5_err",   err_cnt,   64'd2);

    // Back-to-back frames, link drops while word 5 of frame 1 is on the FIFO output.
    base = reads;
    make_frame(20, -1);
    expect_words(5, 1'b1);
    load_fifo(0, 20);
    make_frame(20, -1);
    expect_words(20, 1'b0);
    load_fifo(0, 20);
    n = 0;
    while (reads < base + 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    link_up = 1'b0;
    repeat (6) @(negedge clk);
    link_up = 1'b1;
    wait_drain("t6");
    chk("t6_frame", frame_cnt, 64'd5);
    chk("t6_err",   err_cnt,   64'd3);

    // Random-length frames, random EOP lanes.
    for (int k = 0; k < 8; k++) begin
      make_frame($urandom_range(2, 40), -1);
      expect_words(frm.size(), 1'b0);
      load_fifo(0, frm.size());
      wait_drain("rand");
    end
    chk("rand_frame", frame_cnt, 64'd13);
    chk("rand_err",   err_cnt,   64'd3);

    // Reset in the middle of a frame: outputs idle at once, no error word.
    base = reads;
    make_frame(30, -1);
    expect_words(30, 1'b0);
    load_fifo(0, 30);
    n = 0;
    while (reads < base + 8 && n < 500) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd",      bus.xgmii_txd,  IDLE_D);
    chk("midrst_txc",      bus.xgmii_txc,  64'hFF);
    chk("midrst_underrun", underrun,       64'h0);
    chk("midrst_rdreq",    bus.fifo_rdreq, 64'h0);
    chk("midrst_frame",    frame_cnt,      64'h0);
    exp_q.delete();
    sop_rd.delete();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
